// File: rtl/servo_pkg.sv
// Shared servo definitions: command width, the "off" command, default
// timing constants and the pulse-width helper. Used by servo_handler and
// servo_pwm_driver.
package servo_pkg;

  localparam int CMD_W = 8;

  typedef logic [CMD_W-1:0] servo_cmd_t;

  localparam servo_cmd_t SERVO_OFF = 8'd0;

  // Default timing for a 100 MHz clock: 1 us tick, 20 ms frame,
  // 1 ms floor plus 4 us per command step (cmd 255 -> 2020 us).
  localparam int DEF_TICK_CLKS   = 100;
  localparam int DEF_FRAME_TICKS = 20000;
  localparam int DEF_BASE_TICKS  = 1000;
  localparam int DEF_STEP_TICKS  = 4;
  localparam int DEF_SLEW_STEP   = 8;

  // Pulse width in ticks for a given command.
  function automatic int unsigned servo_width(input servo_cmd_t cmd,
                                              input int unsigned base_ticks,
                                              input int unsigned step_ticks);
    return base_ticks + 32'(cmd) * step_ticks;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: applied-command register (with optional slew limiting
// when SERVO_SLEW_EN is defined), width compare and registered pulse.
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int FW          = 15,
  parameter int BASE_TICKS  = DEF_BASE_TICKS,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  // Frame count that will be current in the cycle after this edge, so the
  // pulse register lines up with the counter it is compared against.
  input  logic [FW-1:0]    fcnt,
  input  logic [CMD_W-1:0] cmd,
  output logic             pwm,
  output logic [CMD_W-1:0] applied
);

  if (SLEW_STEP < 1) begin : g_bad_slew
    $error("servo_pwm_channel: SLEW_STEP must be at least 1");
  end

  logic [CMD_W-1:0] applied_reg;
  logic [CMD_W-1:0] applied_next;
  logic [FW-1:0]    width_next;
  logic             pwm_reg;
  logic             pwm_next;

`ifdef SERVO_SLEW_EN
  localparam logic [CMD_W-1:0] SLEW_V = CMD_W'(SLEW_STEP);
  logic [CMD_W-1:0] diff;

  // At a load, move toward the command by at most SLEW_STEP, landing on it exactly.
  always_comb begin
    applied_next = applied_reg;
    diff         = '0;
    if (load) begin
      if (cmd > applied_reg) begin
        diff         = cmd - applied_reg;
        applied_next = (32'(diff) > SLEW_STEP) ? applied_reg + SLEW_V : cmd;
      end else if (cmd < applied_reg) begin
        diff         = applied_reg - cmd;
        applied_next = (32'(diff) > SLEW_STEP) ? applied_reg - SLEW_V : cmd;
      end
    end
  end
`else
  // At a load, take the command as-is.
  always_comb begin
    applied_next = load ? cmd : applied_reg;
  end
`endif

  // Pulse is high while the upcoming frame count is inside the width.
  always_comb begin
    width_next = FW'(servo_width(applied_next, BASE_TICKS, STEP_TICKS));
    pwm_next   = (applied_next != SERVO_OFF) && (fcnt < width_next);
  end

  // Applied command and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      applied_reg <= SERVO_OFF;
      pwm_reg     <= 1'b0;
    end else begin
      applied_reg <= applied_next;
      pwm_reg     <= pwm_next;
    end
  end

  assign pwm     = pwm_reg;
  assign applied = applied_reg;

endmodule

// File: rtl/servo_pwm_driver.sv
// Dual-channel hobby-servo PWM generator. Commands are latched only at
// frame boundaries; command 0 gives no pulse for the frame.
// Optional feature: define SERVO_SLEW_EN to limit the per-frame change of
// the applied command to SLEW_STEP.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int TICK_CLKS   = DEF_TICK_CLKS,
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int BASE_TICKS  = DEF_BASE_TICKS,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int SLEW_STEP   = DEF_SLEW_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_l,
  input  logic [CMD_W-1:0] cmd_r,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             frame_start,
  output logic [CMD_W-1:0] applied_l,
  output logic [CMD_W-1:0] applied_r
);

  localparam int PW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int FW = $clog2(FRAME_TICKS + 1);

  // The widest pulse must end before the frame does.
  if (TICK_CLKS < 1 || FRAME_TICKS < 2 ||
      BASE_TICKS + ((1 << CMD_W) - 1) * STEP_TICKS >= FRAME_TICKS) begin : g_bad_params
    $error("servo_pwm_driver: illegal timing parameter set");
  end

  logic [PW-1:0] pcnt_reg;
  logic [PW-1:0] pcnt_next;
  logic [FW-1:0] fcnt_reg;
  logic [FW-1:0] fcnt_next;
  logic          start_pending_reg;
  logic          frame_start_reg;
  logic          tick;
  logic          frame_end;
  logic          load;

  // Prescaler, frame counter and load decision. The first load after reset
  // restarts both counters so every frame begins with fcnt at 0.
  always_comb begin
    tick      = (pcnt_reg == PW'(TICK_CLKS - 1));
    frame_end = tick && (fcnt_reg == FW'(FRAME_TICKS - 1));
    load      = start_pending_reg || frame_end;
    pcnt_next = tick ? '0 : pcnt_reg + PW'(1);
    fcnt_next = fcnt_reg;
    if (start_pending_reg) begin
      pcnt_next = '0;
      fcnt_next = '0;
    end else if (frame_end) begin
      fcnt_next = '0;
    end else if (tick) begin
      fcnt_next = fcnt_reg + FW'(1);
    end
  end

  // Counter, pending-start and frame_start registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg          <= '0;
      fcnt_reg          <= '0;
      start_pending_reg <= 1'b1;
      frame_start_reg   <= 1'b0;
    end else begin
      pcnt_reg          <= pcnt_next;
      fcnt_reg          <= fcnt_next;
      start_pending_reg <= 1'b0;
      frame_start_reg   <= load;
    end
  end

  assign frame_start = frame_start_reg;

  logic [CMD_W-1:0] cmd_arr     [2];
  logic [CMD_W-1:0] applied_arr [2];
  logic [1:0]       pwm_vec;

  assign cmd_arr[0] = cmd_l;
  assign cmd_arr[1] = cmd_r;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_ch
    servo_pwm_channel #(
      .FW         (FW),
      .BASE_TICKS (BASE_TICKS),
      .STEP_TICKS (STEP_TICKS),
      .SLEW_STEP  (SLEW_STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .fcnt    (fcnt_next),
      .cmd     (cmd_arr[gi]),
      .pwm     (pwm_vec[gi]),
      .applied (applied_arr[gi])
    );
  end

  assign pwm_l     = pwm_vec[0];
  assign pwm_r     = pwm_vec[1];
  assign applied_l = applied_arr[0];
  assign applied_r = applied_arr[1];

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver with small simulation timing.
// A frame-position model predicts every output each cycle; directed
// scenarios pin measured pulse widths to hand-computed values.
module tb_servo_pwm_driver;

  localparam int T  = 1;
  localparam int F  = 300;
  localparam int B  = 4;
  localparam int S  = 1;
  localparam int SL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd_l = 8'd0;
  logic [7:0] cmd_r = 8'd0;
  logic       pwm_l, pwm_r, frame_start;
  logic [7:0] applied_l, applied_r;

  int checks = 0;
  int errors = 0;

  servo_pwm_driver #(
    .TICK_CLKS   (T),
    .FRAME_TICKS (F),
    .BASE_TICKS  (B),
    .STEP_TICKS  (S),
    .SLEW_STEP   (SL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_l       (cmd_l),
    .cmd_r       (cmd_r),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .frame_start (frame_start),
    .applied_l   (applied_l),
    .applied_r   (applied_r)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks clocks elapsed since the current frame began; a pulse covers the
  // first width*T clocks of the frame.
  function automatic int next_applied(input int a, input int c);
`ifdef SERVO_SLEW_EN
    if (c > a) return (c - a > SL) ? a + SL : c;
    if (c < a) return (a - c > SL) ? a - SL : c;
    return a;
`else
    return c;
`endif
  endfunction

  bit model_valid = 0;
  bit m_pending   = 1;
  int m_k         = 0;
  int m_app_l     = 0;
  int m_app_r     = 0;
  bit exp_pwm_l   = 0;
  bit exp_pwm_r   = 0;
  bit exp_fs      = 0;

  always @(posedge clk) begin
    model_valid = 1;
    if (rst) begin
      m_pending = 1;
      m_app_l   = 0;
      m_app_r   = 0;
      exp_pwm_l = 0;
      exp_pwm_r = 0;
      exp_fs    = 0;
    end else begin
      exp_fs = m_pending || (m_k == F * T - 1);
      if (exp_fs) begin
        m_app_l   = next_applied(m_app_l, int'(cmd_l));
        m_app_r   = next_applied(m_app_r, int'(cmd_r));
        m_k       = 0;
        m_pending = 0;
      end else begin
        m_k++;
      end
      exp_pwm_l = (m_app_l != 0) && (m_k < (B + m_app_l * S) * T);
      exp_pwm_r = (m_app_r != 0) && (m_k < (B + m_app_r * S) * T);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_frame_start", int'(frame_start), int'(exp_fs));
      check("cyc_pwm_l", int'(pwm_l), int'(exp_pwm_l));
      check("cyc_pwm_r", int'(pwm_r), int'(exp_pwm_r));
      check("cyc_applied_l", int'(applied_l), m_app_l);
      check("cyc_applied_r", int'(applied_r), m_app_r);
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_frame(output int n);
    bit ok;
    ok = 0;
    n  = 0;
    while (n < 1000 && !ok) begin
      @(negedge clk);
      n++;
      if (frame_start) ok = 1;
    end
    check("frame_start_timeout", int'(ok), 1);
  endtask

  // Called on a frame_start cycle; returns at the next frame_start cycle.
  task automatic measure_frame(output int hl, output int hr, output int len);
    hl = 0; hr = 0; len = 0;
    do begin
      hl += int'(pwm_l);
      hr += int'(pwm_r);
      len++;
      @(negedge clk);
    end while (!frame_start && len < 1000);
  endtask

  function automatic logic [7:0] pick_cmd();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'd255;
    if (r == 2) return 8'd1;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, hl, hr, len, rst_left;
    repeat (3) @(negedge clk);
    check("reset_pwm_l", int'(pwm_l), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_applied_l", int'(applied_l), 0);

`ifndef SERVO_SLEW_EN
    // Release with cmd_l=10, cmd_r=0.
    cmd_l = 8'd10; cmd_r = 8'd0; rst = 1'b0;
    wait_frame(n);
    check("s1_first_frame_start", n, 1);
    check("s1_applied_l", int'(applied_l), 10);
    measure_frame(hl, hr, len);
    $display("s1 frame: pwm_l %0d pwm_r %0d len %0d", hl, hr, len);
    check("s1_width_l", hl, 14);
    check("s1_width_r", hr, 0);
    check("s1_period", len, 300);

    // Mid-frame change 10 -> 200.
    fork
      measure_frame(hl, hr, len);
      begin repeat (150) @(negedge clk); cmd_l = 8'd200; end
    join
    $display("s2 frame A: pwm_l %0d len %0d", hl, len);
    check("s2_width_unchanged", hl, 14);
    check("s2_applied_l", int'(applied_l), 200);
    cmd_l = 8'd255;
    measure_frame(hl, hr, len);
    $display("s2 frame B: pwm_l %0d len %0d", hl, len);
    check("s2_width_new", hl, 204);

    // Maximum command over five frames.
    for (int f = 0; f < 5; f++) begin
      check("s3_applied_l", int'(applied_l), 255);
      measure_frame(hl, hr, len);
      $display("s3 frame %0d: pwm_l %0d low %0d", f, hl, len - hl);
      check("s3_width", hl, 259);
      check("s3_low", len - hl, 41);
    end

    // Reset while the pulse is high.
    check("s4_pwm_high_before", int'(pwm_l), 1);
    rst = 1'b1;
    @(negedge clk);
    check("s4_pwm_low_after_rst", int'(pwm_l), 0);
    repeat (2) @(negedge clk);
    cmd_l = 8'd10;
    rst = 1'b0;
    wait_frame(n);
    $display("s4 restart: frame_start after %0d clk", n);
    check("s4_restart_latency", n, 1);

    // Command change presented exactly at the load edge.
    repeat (299) @(negedge clk);
    cmd_l = 8'd137; cmd_r = 8'd137;
    @(negedge clk);
    check("s6_frame_start", int'(frame_start), 1);
    check("s6_applied_l", int'(applied_l), 137);
    check("s6_applied_r", int'(applied_r), 137);
    measure_frame(hl, hr, len);
    $display("s6 frame: pwm_l %0d pwm_r %0d len %0d", hl, hr, len);
    check("s6_width_l", hl, 141);
    check("s6_width_r", hr, 141);
`else
    // Slew from 0 toward 20.
    cmd_l = 8'd0; cmd_r = 8'd0; rst = 1'b0;
    wait_frame(n);
    check("s5_first_frame_start", n, 1);
    check("s5_applied_start", int'(applied_l), 0);
    cmd_l = 8'd20;
    measure_frame(hl, hr, len);
    check("s5_width_off", hl, 0);
    for (int f = 0; f < 4; f++) begin
      int ea, ew;
      ea = (f == 0) ? 8 : (f == 1) ? 16 : 20;
      ew = (f == 0) ? 12 : (f == 1) ? 20 : 24;
      check("s5_applied", int'(applied_l), ea);
      measure_frame(hl, hr, len);
      $display("s5 frame %0d: applied_l %0d pwm_l %0d", f, ea, hl);
      check("s5_width", hl, ew);
    end
`endif

    // Randomized commands and occasional resets, checked cycle by cycle.
    rst_left = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) cmd_l = pick_cmd();
      if ($urandom_range(0, 149) == 0) cmd_r = pick_cmd();
      if (rst) begin
        if (rst_left == 0) rst = 1'b0;
        else rst_left--;
      end else if ($urandom_range(0, 2499) == 0) begin
        rst = 1'b1;
        rst_left = $urandom_range(0, 2);
      end
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
